// File: rtl/aes128_iter_cipher_if.sv
// aes128_iter_cipher_if
//   Plaintext-in / ciphertext-out streaming bus for the iterative AES-128 core.
//
//   Handshake: a transfer happens on a rising clk edge where valid and ready
//   are both 1. Once valid is raised, the source holds it and its data stable
//   until that edge. Ready may change freely, and valid never waits on ready.
//
//   Signals
//     in_valid   master->slave  plaintext block offered
//     in_ready   slave->master  core can take a block
//     in_data    master->slave  128-bit plaintext, byte 0 in bits [127:120]
//     out_valid  slave->master  ciphertext available
//     out_ready  master->slave  downstream takes the ciphertext
//     out_data   slave->master  128-bit ciphertext, same byte order
interface aes128_iter_cipher_if;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_data;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_data;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/aes128_iter_cipher.sv
// aes128_iter_cipher
//   Iterative AES-128 encryption with one round per clock and one block in
//   flight. The eleven round keys come from an upstream key expander. They
//   are not latched, so they must stay stable from accept until the ciphertext
//   handshake.
//
//   Ports
//     clk         rising-edge clock
//     rst         synchronous, active-high reset
//     round_keys  round_keys[128*i +: 128] = sk_i, i = 0..10
//     bus         slave side of aes128_iter_cipher_if (plaintext in, ciphertext out)
//     busy        high while a block is in flight (ROUND or DONE)
//     dbg_state   current FSM state (IDLE=0, ROUND=1, DONE=2)
module aes128_iter_cipher #(
  parameter int NUM_ROUNDS = 10
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [1407:0]           round_keys,
  aes128_iter_cipher_if.slave     bus,
  output logic                    busy,
  output logic [1:0]              dbg_state
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ROUND = 2'd1,
    DONE  = 2'd2
  } fsm_t;

  localparam logic [3:0] LAST_ROUND = 4'(NUM_ROUNDS);

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  // Multiply by x in GF(2^8) modulo x^8 + x^4 + x^3 + x + 1 (0x11b).
  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  // One full AES round. Byte i of the state sits in bits [127-8i -: 8], and
  // the layout is column-major, so byte (row r, column c) has index r + 4c.
  function automatic logic [127:0] cipher_round(
    input logic [127:0] s,
    input logic [127:0] k,
    input logic         last
  );
    logic [7:0]   sb [16];
    logic [7:0]   sr [16];
    logic [7:0]   mc [16];
    logic [127:0] r;
    for (int i = 0; i < 16; i++) sb[i] = SBOX[s[127-8*i -: 8]];
    // Row r rotates left by r columns.
    for (int c = 0; c < 4; c++)
      for (int rw = 0; rw < 4; rw++)
        sr[rw + 4*c] = sb[rw + 4*((c + rw) % 4)];
    for (int c = 0; c < 4; c++) begin
      mc[4*c+0] = xtime(sr[4*c+0]) ^ xtime(sr[4*c+1]) ^ sr[4*c+1] ^ sr[4*c+2] ^ sr[4*c+3];
      mc[4*c+1] = sr[4*c+0] ^ xtime(sr[4*c+1]) ^ xtime(sr[4*c+2]) ^ sr[4*c+2] ^ sr[4*c+3];
      mc[4*c+2] = sr[4*c+0] ^ sr[4*c+1] ^ xtime(sr[4*c+2]) ^ xtime(sr[4*c+3]) ^ sr[4*c+3];
      mc[4*c+3] = xtime(sr[4*c+0]) ^ sr[4*c+0] ^ sr[4*c+1] ^ sr[4*c+2] ^ xtime(sr[4*c+3]);
    end
    for (int i = 0; i < 16; i++) r[127-8*i -: 8] = last ? sr[i] : mc[i];
    return r ^ k;
  endfunction

  fsm_t         fsm;
  logic [127:0] state_r;
  logic [3:0]   round_r;
  logic         in_ready_r;
  logic         out_valid_r;
  logic         busy_r;
  logic [127:0] sk [16];
  logic [127:0] round_out;

  // Key slots beyond the last round read as zero, so round_r can index the
  // array directly without a range check.
  for (genvar g = 0; g < 16; g++) begin : g_sk
    if (g <= NUM_ROUNDS) begin : g_used
      assign sk[g] = round_keys[128*g +: 128];
    end else begin : g_unused
      assign sk[g] = '0;
    end
  end

  always_comb begin
    round_out = cipher_round(state_r, sk[round_r], round_r == LAST_ROUND);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fsm         <= IDLE;
      state_r     <= '0;
      round_r     <= '0;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      case (fsm)
        IDLE: begin
          if (bus.in_valid) begin
            state_r    <= bus.in_data ^ sk[0];
            round_r    <= 4'd1;
            fsm        <= ROUND;
            in_ready_r <= 1'b0;
            busy_r     <= 1'b1;
          end
        end
        ROUND: begin
          state_r <= round_out;
          if (round_r == LAST_ROUND) begin
            // round_r parks at the last round, so it never goes past 10.
            fsm         <= DONE;
            out_valid_r <= 1'b1;
          end else begin
            round_r <= round_r + 4'd1;
          end
        end
        DONE: begin
          // in_ready returns only on the next cycle, so a new block can never
          // be accepted on the same edge as the output handoff.
          if (bus.out_ready) begin
            fsm         <= IDLE;
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
            busy_r      <= 1'b0;
          end
        end
        default: begin
          fsm         <= IDLE;
          in_ready_r  <= 1'b1;
          out_valid_r <= 1'b0;
          busy_r      <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_r;
  assign bus.out_valid = out_valid_r;
  assign bus.out_data  = state_r;
  assign busy          = busy_r;
  assign dbg_state     = fsm;

endmodule

// File: doc/aes128_iter_cipher.md
Name: aes128_iter_cipher

Overview:
- Iterative AES-128 encryption core; one round per clock.
- Sits directly downstream of aes_key_expand_128 and consumes its eleven 128-bit round keys (sk0..sk10) on a flattened bus.
- Accepts one 128-bit plaintext block over a valid/ready handshake and returns the ciphertext over a second valid/ready handshake.
- Holds a single block in flight; no pipelining.

Parameters:
- NUM_ROUNDS, 10, number of cipher rounds. 10 is the only supported value (AES-128). Any other value is out of scope.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous reset, active-high.
- round_keys  in  1408  round_keys[128*i +: 128] = sk_i for i = 0..10, wired from aes_key_expand_128 outputs.
- in_valid  in  1  plaintext valid.
- in_ready  out  1  core can accept a block.
- in_data  in  128  plaintext; byte 0 = bits [127:120], column-major state as in FIPS-197.
- out_valid  out  1  ciphertext valid.
- out_ready  in  1  downstream accepts ciphertext.
- out_data  out  128  ciphertext, same byte order as in_data.
- busy  out  1  high while a block is in flight (ROUND or DONE).

Behaviour:
- FSM states: IDLE, ROUND, DONE. Registers: state_r[127:0], round_r[3:0].
- Reset (rst=1 at clk edge), overriding all else, including mid-operation:
  - FSM -> IDLE; state_r = 0; round_r = 0.
  - out_valid = 0; in_ready = 1 after reset releases; busy = 0; out_data = 0.
  - Any in-flight block is dropped silently.
- IDLE:
  - in_ready = 1.
  - On an edge with in_valid = 1: state_r <= in_data ^ sk0; round_r <= 1; go to ROUND.
- ROUND:
  - in_ready = 0; in_valid is ignored.
  - Each edge applies round round_r to state_r.
  - Rounds 1..9: SubBytes, ShiftRows, MixColumns, AddRoundKey(sk_round_r).
  - Round 10: SubBytes, ShiftRows, AddRoundKey(sk10); no MixColumns.
  - round_r increments each edge. On the edge that applies round 10, go to DONE.
- DONE:
  - out_valid = 1; out_data = state_r, held stable until the handshake.
  - On an edge with out_ready = 1: go to IDLE, out_valid -> 0.
  - in_ready stays 0 in DONE, so a new block cannot be accepted in the same cycle as output handoff. The earliest new accept is the cycle after.
- Latency and throughput:
  - Acceptance edge E0. out_valid is high in the cycle after edge E10, i.e. 10 cycles after acceptance.
  - Minimum issue interval is 12 cycles per block.
- Key stability: round_keys must be stable from the accept edge until the output handshake. The core does not latch keys. The bench checks that a key change while busy = 1 is a protocol violation, not a supported feature.
- out_data is only meaningful while out_valid = 1. While out_valid = 0 it reflects state_r (don't-care for checkers).
- S-box: combinational 256-entry lookup per byte, 16 instances.
- MixColumns: GF(2^8), xtime with reduction polynomial 0x11b.
- round_r never exceeds 10; no wrap-around states are reachable.
- out_ready held high in IDLE or ROUND has no effect.
- in_valid held high continuously yields back-to-back blocks at the 12-cycle interval.

Test Plan:
- FIPS-197 App. B: key 2b7e151628aed2a6abf7158809cf4f3c, pt 3243f6a8885a308d313198a2e0370734 -> out_data 3925841d02dc09fbdc118597196a0b32. out_valid rises exactly 10 cycles after accept.
- FIPS-197 App. C.1: key 000102030405060708090a0b0c0d0e0f, pt 00112233445566778899aabbccddeeff -> 69c4e0d86a7b0430d8cdb78070b4c55a.
- Zero key, zero pt -> 66e94bd4ef8a2c3b884cfa59ca342b2e. Hold out_ready = 0 for 5 cycles: out_valid and out_data stay stable, in_ready = 0 throughout.
- Back-to-back: in_valid held high with two blocks (App. B then C.1 pt, each with its matching key), out_ready = 1 -> second accept occurs 12 cycles after the first; both results correct.
- Reset mid-operation: assert rst during round 5 -> next cycle is IDLE, in_ready = 1, out_valid = 0, busy = 0. A fresh App. B block then yields 3925841d02dc09fbdc118597196a0b32.
- in_valid pulsed during ROUND and DONE -> ignored; exactly one output per accepted block.
